// File: rtl/sobel_window_buffer.sv
// sobel_window_buffer: raster pixel stream in, 3x3 neighbourhood out.
// Two line buffers hold the previous rows; one valid pulse per full window.
module sobel_window_buffer #(
  parameter int IMG_WIDTH = 8,
  parameter int PX_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [PX_WIDTH-1:0]   px_i,
  input  logic                  px_valid_i,
  input  logic                  frame_start_i,
  output logic [9*PX_WIDTH-1:0] window_o,
  output logic                  window_valid_o
);

  localparam int CW = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);

  typedef logic [PX_WIDTH-1:0] px_t;

  logic [CW-1:0] col;
  logic [CW-1:0] col_eff;
  logic [CW-1:0] col_nxt;
  logic [1:0]    row;
  logic [1:0]    row_eff;
  logic [1:0]    row_nxt;
  logic          win_done;
  px_t           tap_top;
  px_t           tap_mid;

  px_t lb0 [IMG_WIDTH];
  px_t lb1 [IMG_WIDTH];
  px_t win [3][3];

  // a coincident frame_start makes this pixel (0,0) of the new frame
  always_comb begin
    col_eff  = frame_start_i ? '0 : col;
    row_eff  = frame_start_i ? '0 : row;
    tap_top  = lb1[col_eff];
    tap_mid  = lb0[col_eff];
    win_done = (row_eff == 2'd2) && (col_eff >= COL_TWO);
    col_nxt  = col_eff + CW'(1);
    row_nxt  = row_eff;
    if (col_eff == COL_LAST) begin
      col_nxt = '0;
      if (row_eff != 2'd2) begin
        row_nxt = row_eff + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      col            <= '0;
      row            <= '0;
      window_valid_o <= 1'b0;
      for (int i = 0; i < IMG_WIDTH; i++) begin
        lb0[i] <= '0;
        lb1[i] <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      window_valid_o <= 1'b0;
      if (frame_start_i) begin
        col <= '0;
        row <= '0;
      end
      if (px_valid_i) begin
        lb1[col_eff] <= tap_mid;
        lb0[col_eff] <= px_i;
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2]      <= tap_top;
        win[1][2]      <= tap_mid;
        win[2][2]      <= px_i;
        window_valid_o <= win_done;
        col            <= col_nxt;
        row            <= row_nxt;
      end
    end
  end

  for (genvar gr = 0; gr < 3; gr++) begin : g_row
    for (genvar gc = 0; gc < 3; gc++) begin : g_col
      assign window_o[(3*gr+gc)*PX_WIDTH +: PX_WIDTH] = win[gr][gc];
    end
  end

endmodule

// File: doc/sobel_window_buffer.md
# sobel_window_buffer

Streaming 3x3 window generator between `spi_control` and the Sobel kernel. It takes the grayscale pixels that `spi_control` delivers one at a time, in raster order, with a single-cycle ready pulse. It holds the two previous image rows in internal line buffers. For every pixel that completes a full 3x3 neighbourhood, it presents that neighbourhood in parallel with a one-cycle valid pulse, so the kernel can compute one gradient per received pixel.

## Interface
Parameters:
- `IMG_WIDTH`, default 8: pixels per image row; must be ≥ 3.
- `PX_WIDTH`, default 8: bits per gray pixel. The top level drives `px_i` from `input_px_gray_o[PX_WIDTH-1:0]`.

Ports:
- `clk_i`  in  1  system clock; all logic on the rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `px_i`  in  PX_WIDTH  incoming gray pixel.
- `px_valid_i`  in  1  pixel strobe, driven by `px_rdy_i_spi_o`. Each high cycle accepts exactly one pixel.
- `frame_start_i`  in  1  synchronous restart of the position counters for a new frame.
- `window_o`  out  9*PX_WIDTH  3x3 window. Element k is `window_o[k*PX_WIDTH +: PX_WIDTH]`, with k = 3*r + c:
  - r = 0 is the oldest row, r = 2 the current row;
  - c = 0 is the leftmost column, c = 2 the newest column;
  - the centre is k = 4.
- `window_valid_o`  out  1  one-cycle pulse marking `window_o` as a new complete window.

## Operation
- State:
  - column counter `col`, range 0..IMG_WIDTH-1;
  - row-depth counter `row`, saturating at 2;
  - line buffer `lb0[IMG_WIDTH]`, holding the previous row;
  - line buffer `lb1[IMG_WIDTH]`, holding the row two back;
  - window register file, 3 columns x 3 rows.
- On an accepted pixel (`px_valid_i` = 1):
  - read the taps at the current `col`: top = `lb1[col]`, mid = `lb0[col]`, bot = `px_i`;
  - write `lb1[col]` ← `lb0[col]` and `lb0[col]` ← `px_i`;
  - shift the window left: column 0 ← column 1, column 1 ← column 2, column 2 ← {top, mid, bot};
  - set `window_valid_o` for the next cycle if and only if `row` == 2 and `col` ≥ 2, using the counter values before the update;
  - advance `col`. At `col` = IMG_WIDTH-1 it wraps to 0 and `row` increments, saturating at 2.
- No edge padding is applied. Per frame there are exactly (rows-2)*(IMG_WIDTH-2) valid pulses, and windows never straddle a row boundary.
- `frame_start_i` = 1 clears `col` and `row` to 0.
  - Line buffer contents are left as they are; they cannot produce a valid window until two full rows have been written again.
  - If `frame_start_i` and `px_valid_i` are high in the same cycle, the pixel is accepted as pixel (0,0) of the new frame: its counter update uses col = row = 0, giving next `col` = 1 and `row` = 0.
- Cycles with `px_valid_i` = 0 change nothing except that `window_valid_o` drops to 0. Gaps of any length are transparent.
- There is no back-pressure. The downstream kernel must consume each window within the gap between strobes; `spi_control` guarantees at least 16 SPI clocks per pixel.

## Timing
- Reset (`reset_i` high, asynchronous):
  - `col`, `row`, both line buffers and all window registers go to 0;
  - `window_o` = 0 and `window_valid_o` = 0.
- Reset asserted mid-frame discards all history. The first valid after release needs two full rows plus 3 pixels.
- Latency: a pixel accepted at edge N produces `window_o` and `window_valid_o` = 1 during cycle N+1, i.e. one clock.
- `window_valid_o` stays high for exactly one cycle, even for back-to-back strobes: consecutive strobes give consecutive pulses.
- `window_o` holds its value until the next accepted pixel, including across invalid periods.
- Line buffer reads are combinational from registers or LUT-RAM; no extra read cycle is allowed.

## Test plan
- Reset: hold `reset_i` with random inputs → `window_o` = 0 and `window_valid_o` = 0. Release, then send 2*IMG_WIDTH+2 pixels → no valid pulse.
- Raster 4x4 (IMG_WIDTH = 4), pixel value = index 0..15, back-to-back strobes:
  - the first pulse follows pixel 10, with window {0,1,2,4,5,6,8,9,10};
  - exactly 4 pulses in total;
  - the last window is {5,6,7,9,10,11,13,14,15}.
- Same 4x4 stream with 0–5 random idle cycles between strobes → identical window sequence and pulse count; every pulse lasts one cycle.
- `frame_start_i` asserted after pixel 9, then a fresh 4x4 frame with values 100..115 → no pulse until the new pixel index 10; the first window is {100,101,102,104,105,106,108,109,110}.
- `frame_start_i` coincident with the first pixel of a frame → behaves exactly like the separate-cycle case; counters end at col = 1, row = 0.
- `reset_i` pulsed asynchronously, between clock edges, after pixel 12 of a frame → outputs are 0 immediately. A subsequent full frame yields a first window built only from post-reset pixels.
